// File: rtl/cnn_layer_sequencer.sv
// Frame sequencer for a conv/pool datapath: streams n*n activations from the
// activation buffer into the datapath and collects pooled results into the result buffer.
`timescale 1ns/1ps
module cnn_layer_sequencer #(
    parameter int N         = 16,
    parameter int n         = 6,
    parameter int k         = 3,
    parameter int p         = 2,
    parameter int s         = 1,
    parameter int ADDR_W    = 6,
    parameter int DRAIN_MAX = 64
) (
    input  logic              clk,
    input  logic              global_rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_avail,
    input  logic [N-1:0]      rd_data,
    output logic              blk_rst,
    output logic              blk_ce,
    output logic [N-1:0]      blk_activation,
    input  logic              blk_valid_op,
    input  logic [N-1:0]      blk_data_out,
    input  logic              blk_end_op,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [N-1:0]      wr_data
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CLR    = 3'd1;
    localparam logic [2:0] S_STREAM = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam int P_SIDE = ((n - k) / s + 1) / p;
    localparam int P_CNT  = P_SIDE * P_SIDE;
    localparam int DCNT_W = $clog2(DRAIN_MAX + 1);

    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(n * n - 1);
    localparam logic [ADDR_W:0]   P_CNT_W    = (ADDR_W + 1)'(P_CNT);
    localparam logic [DCNT_W-1:0] DRAIN_LAST = DCNT_W'(DRAIN_MAX - 1);

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DCNT_W-1:0] drain_cnt_q, drain_cnt_d;
    logic              rd_vld_q, rd_vld_d;
    logic              err_q, err_d;

    logic              in_stream, in_drain, in_run;
    logic [ADDR_W:0]   wr_total;

    always_comb begin
        in_stream = (state_q == S_STREAM);
        in_drain  = (state_q == S_DRAIN);
        in_run    = in_stream | in_drain;
        rd_en     = in_stream & rd_avail;
        wr_en     = in_run & blk_valid_op;
        // Writes completed including one landing in this same cycle.
        wr_total  = {1'b0, wr_addr_q} + {{ADDR_W{1'b0}}, wr_en};
    end

    always_comb begin
        state_d     = state_q;
        rd_addr_d   = rd_addr_q;
        wr_addr_d   = wr_addr_q;
        drain_cnt_d = drain_cnt_q;
        err_d       = err_q;
        rd_vld_d    = rd_en;

        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_CLR;
            end
            S_CLR: begin
                rd_addr_d   = '0;
                wr_addr_d   = '0;
                drain_cnt_d = '0;
                err_d       = 1'b0;
                state_d     = S_STREAM;
            end
            S_STREAM: begin
                if (rd_en) begin
                    rd_addr_d = rd_addr_q + ADDR_W'(1);
                    if (rd_addr_q == LAST_ADDR) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                drain_cnt_d = drain_cnt_q + DCNT_W'(1);
                if (drain_cnt_q == DRAIN_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Result collection and frame-end handling are shared by STREAM and DRAIN.
        if (in_run) begin
            if (wr_en) begin
                wr_addr_d = wr_addr_q + ADDR_W'(1);
                if ({1'b0, wr_addr_q} >= P_CNT_W) err_d = 1'b1;
            end
            if (blk_end_op) begin
                state_d = S_DONE;
                if (wr_total != P_CNT_W) err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge global_rst_n) begin
        if (!global_rst_n) begin
            state_q     <= S_IDLE;
            rd_addr_q   <= '0;
            wr_addr_q   <= '0;
            drain_cnt_q <= '0;
            rd_vld_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_addr_q   <= rd_addr_d;
            wr_addr_q   <= wr_addr_d;
            drain_cnt_q <= drain_cnt_d;
            rd_vld_q    <= rd_vld_d;
            err_q       <= err_d;
        end
    end

    // Read data lands one cycle after the strobe; DRAIN keeps clocking zeros through.
    always_comb begin
        busy           = (state_q != S_IDLE);
        done           = (state_q == S_DONE);
        blk_rst        = (state_q == S_CLR);
        err            = err_q;
        rd_addr        = rd_addr_q;
        wr_addr        = wr_addr_q;
        blk_ce         = (in_stream & rd_vld_q) | in_drain;
        blk_activation = rd_vld_q ? rd_data : '0;
        wr_data        = wr_en ? blk_data_out : '0;
    end

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Directed bench for cnn_layer_sequencer: table of whole-frame scenarios with a
// behavioural buffer/datapath model, plus hand-written reset sequences.
`timescale 1ns/1ps
module tb_cnn_layer_sequencer;
    localparam int N        = 16;
    localparam int ADDR_W   = 6;
    localparam int STALL_AT = 10;
    localparam int LAST     = 35;

    logic              clk = 1'b0;
    logic              global_rst_n = 1'b0;
    logic              start = 1'b0;
    logic              rd_avail = 1'b0;
    logic [N-1:0]      rd_data = '0;
    logic              blk_valid_op = 1'b0;
    logic [N-1:0]      blk_data_out = '0;
    logic              blk_end_op = 1'b0;
    logic              busy, done, err, rd_en, blk_rst, blk_ce, wr_en;
    logic [ADDR_W-1:0] rd_addr, wr_addr;
    logic [N-1:0]      blk_activation, wr_data;

    cnn_layer_sequencer dut (
        .clk(clk), .global_rst_n(global_rst_n), .start(start),
        .busy(busy), .done(done), .err(err),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_avail(rd_avail), .rd_data(rd_data),
        .blk_rst(blk_rst), .blk_ce(blk_ce), .blk_activation(blk_activation),
        .blk_valid_op(blk_valid_op), .blk_data_out(blk_data_out), .blk_end_op(blk_end_op),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        int stall_len;
        int end_mode;      // 0: end after all results, 1: end with 2nd result, 2: never end
        int inject_start;
        int exp_reads;
        int exp_run;
        int exp_ce;
        int exp_writes;
        int exp_err;
        int exp_drain;
    } frame_t;

    frame_t tbl[5];
    int     vt[4] = '{14, 17, 32, 35};
    int     passed = 0;
    int     total  = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: actual %0d required %0d", name, act, exp);
    endtask

    task automatic run_frame(input int fi, input frame_t f);
        int reads = 0, run = 0, max_run = 0, ce_cnt = 0, ce_err = 0, gap = 0;
        int hold_err = 0, order_err = 0, writes = 0, wr_err = 0, drain = 0;
        int done_cnt = 0, rst_cnt = 0, act_cnt = 0, vidx = 0, stall_left = 0, cycles = 0;
        bit stall_started = 0, end_sent = 0, prev_rd_en = 0, drain_phase = 0;
        bit last_seen = 0, exp_ce = 0, got_done = 0;
        logic [ADDR_W-1:0] prev_addr = '0;
        string pfx;
        pfx = $sformatf("f%0d", fi);

        @(negedge clk);
        start = 1'b1;
        while (!got_done && cycles < 400) begin
            @(negedge clk);
            cycles++;
            start    = (f.inject_start != 0) && (cycles == 8);
            rd_data  = prev_rd_en ? (N'(prev_addr) + N'(100)) : 16'hDEAD;
            rd_avail = 1'b1;
            if (f.stall_len > 0 && !stall_started && busy && !blk_rst && rd_addr == ADDR_W'(STALL_AT)) begin
                stall_started = 1;
                stall_left    = f.stall_len;
            end
            if (stall_left > 0) begin
                rd_avail = 1'b0;
                stall_left--;
                if (rd_addr != ADDR_W'(STALL_AT)) hold_err++;
            end
            blk_valid_op = 1'b0;
            blk_end_op   = 1'b0;
            blk_data_out = '0;
            if (vidx < 4 && act_cnt >= vt[vidx]) begin
                blk_valid_op = 1'b1;
                blk_data_out = N'(16'h1000 + vidx);
                vidx++;
                if (f.end_mode == 1 && vidx == 2) blk_end_op = 1'b1;
            end
            if (f.end_mode == 0 && vidx == 4 && act_cnt >= 38 && !end_sent) begin
                blk_end_op = 1'b1;
                end_sent   = 1;
            end
            #1;
            if (blk_rst) rst_cnt++;
            if (done) done_cnt++;
            if (busy && !blk_rst) begin
                exp_ce = !done && (prev_rd_en || drain_phase);
                if (blk_ce !== exp_ce) ce_err++;
                if (blk_ce && prev_rd_en) begin
                    ce_cnt++;
                    if (blk_activation !== (N'(prev_addr) + N'(100))) ce_err++;
                end else if (blk_ce && blk_activation !== '0) ce_err++;
                if (!blk_ce && !done && act_cnt > 0) gap++;
            end
            if (rd_en) begin
                if (rd_addr != ADDR_W'(reads)) order_err++;
                reads++;
                run++;
                if (run > max_run) max_run = run;
                if (rd_addr == ADDR_W'(LAST)) last_seen = 1;
            end else run = 0;
            if (wr_en !== blk_valid_op) wr_err++;
            if (wr_en) begin
                if (wr_addr != ADDR_W'(writes) || wr_data != N'(16'h1000 + writes)) wr_err++;
                writes++;
            end
            if (drain_phase && !done) drain++;
            if (blk_ce) act_cnt++;
            prev_rd_en  = rd_en;
            prev_addr   = rd_addr;
            drain_phase = drain_phase | last_seen;
            if (done) got_done = 1;
        end
        start        = 1'b0;
        blk_valid_op = 1'b0;
        blk_end_op   = 1'b0;
        chk({pfx, "_done_reached"}, int'(got_done), 1);
        chk({pfx, "_reads"}, reads, f.exp_reads);
        chk({pfx, "_read_order_errs"}, order_err, 0);
        chk({pfx, "_max_read_run"}, max_run, f.exp_run);
        chk({pfx, "_ce_act_cycles"}, ce_cnt, f.exp_ce);
        chk({pfx, "_ce_errs"}, ce_err, 0);
        chk({pfx, "_ce_gap"}, gap, f.stall_len);
        chk({pfx, "_stall_hold_errs"}, hold_err, 0);
        chk({pfx, "_writes"}, writes, f.exp_writes);
        chk({pfx, "_write_errs"}, wr_err, 0);
        chk({pfx, "_drain_cycles"}, drain, f.exp_drain);
        chk({pfx, "_done_pulses"}, done_cnt, 1);
        chk({pfx, "_blk_rst_cycles"}, rst_cnt, 1);
        @(negedge clk);
        #1;
        chk({pfx, "_busy_after"}, int'(busy), 0);
        chk({pfx, "_done_after"}, int'(done), 0);
        chk({pfx, "_err_final"}, int'(err), f.exp_err);
    endtask

    initial begin
        int n_wait;
        tbl[0] = '{0, 0, 0, 36, 36, 36, 4, 0, 4};
        tbl[1] = '{5, 0, 0, 36, 26, 36, 4, 0, 4};
        tbl[2] = '{0, 2, 0, 36, 36, 36, 4, 1, 64};
        tbl[3] = '{0, 1, 0, 19, 19, 18, 2, 1, 0};
        tbl[4] = '{0, 0, 1, 36, 36, 36, 4, 0, 4};

        // Power-on reset with busy-looking inputs: every output must stay zero.
        rd_avail     = 1'b1;
        blk_valid_op = 1'b1;
        blk_data_out = '1;
        rd_data      = '1;
        start        = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_flags", int'({busy, done, err, rd_en, blk_rst, blk_ce, wr_en}), 0);
        chk("rst_rd_addr", int'(rd_addr), 0);
        chk("rst_wr_addr", int'(wr_addr), 0);
        chk("rst_activation", int'(blk_activation), 0);
        chk("rst_wr_data", int'(wr_data), 0);
        @(negedge clk);
        start        = 1'b0;
        blk_valid_op = 1'b0;
        blk_data_out = '0;
        global_rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("idle_busy", int'(busy), 0);

        // Abandon a frame mid-stream with an asynchronous reset.
        @(negedge clk);
        start    = 1'b1;
        rd_avail = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        n_wait = 0;
        while (rd_addr != ADDR_W'(20) && n_wait < 100) begin
            @(negedge clk);
            n_wait++;
        end
        chk("midrst_addr_reached", int'(rd_addr), 20);
        #3;
        global_rst_n = 1'b0;
        #1;
        chk("midrst_flags", int'({busy, done, err, rd_en, blk_rst, blk_ce, wr_en}), 0);
        chk("midrst_rd_addr", int'(rd_addr), 0);
        chk("midrst_activation", int'(blk_activation), 0);
        @(negedge clk);
        global_rst_n = 1'b1;
        #1;
        chk("midrst_busy_after", int'(busy), 0);
        chk("midrst_done_after", int'(done), 0);

        for (int i = 0; i < 5; i++) run_frame(i, tbl[i]);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
